// File: rtl/bram1be_client_pkg.sv
// Shared helpers for the byte-enable BRAM client: read latency, widths and
// the response-depth legality rule.
package bram1be_client_pkg;

   function automatic int rd_latency(input int pipelined);
      return 1 + pipelined;
   endfunction

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

   // One slot per in-flight read plus one being drained.
   function automatic bit depth_ok(input int depth, input int pipelined);
      return depth >= rd_latency(pipelined) + 1;
   endfunction

endpackage

// File: rtl/bram1be_rsp_fifo.sv
// First-word-fall-through response FIFO; DEPTH need not be a power of two.
module bram1be_rsp_fifo
   import bram1be_client_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           i_push,
   input  logic [DATA_WIDTH-1:0]          i_push_data,
   input  logic                           i_pop,
   output logic                           o_valid,
   output logic [DATA_WIDTH-1:0]          o_data,
   output logic [clog2(DEPTH + 1)-1:0]    o_count
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CNT_W = clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   // Storage is left untouched by reset; only the bookkeeping clears.
   always_ff @(posedge CLK) begin
      if (i_push && !RST) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/bram1be_client.sv
// Initiator-side adapter for a single-port byte-enable BRAM: passes requests
// straight through, tracks read latency and buffers responses under credit.
module bram1be_client
   import bram1be_client_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int CHUNKSIZE  = 8,
   parameter int WE_WIDTH   = 4,
   parameter int PIPELINED  = 0,
   parameter int RESP_DEPTH = 4,
   parameter int WRITE_RSP  = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic [WE_WIDTH-1:0]   REQ_WE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ_DATA,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   output logic                  BRAM_EN,
   output logic [WE_WIDTH-1:0]   BRAM_WE,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [DATA_WIDTH-1:0] BRAM_DI,
   input  logic [DATA_WIDTH-1:0] BRAM_DO
);

   localparam int L     = rd_latency(PIPELINED);
   localparam int CNT_W = clog2(RESP_DEPTH + 1);

   if (!depth_ok(RESP_DEPTH, PIPELINED)) begin : g_bad_depth
      $error("bram1be_client: RESP_DEPTH must be at least read latency + 1");
   end
   if (DATA_WIDTH != CHUNKSIZE * WE_WIDTH) begin : g_bad_width
      $error("bram1be_client: DATA_WIDTH must equal CHUNKSIZE * WE_WIDTH");
   end

   logic             w_fire;
   logic             w_rsp_exp;
   logic             w_credit_ok;
   logic             w_fifo_valid;
   logic             w_pop;
   logic [CNT_W-1:0] w_count;
   logic [L-1:0]     r_exp;

   // Credit uses the pre-pop count so acceptance never depends on RSP_READY.
   assign w_credit_ok = (int'(w_count) + $countones(r_exp)) < RESP_DEPTH;
   assign REQ_READY   = ~RST & w_credit_ok;
   assign w_fire      = REQ_VALID & REQ_READY;
   assign w_rsp_exp   = w_fire & (~|REQ_WE | (WRITE_RSP != 0));

   assign BRAM_EN   = w_fire;
   assign BRAM_WE   = REQ_WE & {WE_WIDTH{w_fire}};
   assign BRAM_ADDR = REQ_ADDR;
   assign BRAM_DI   = REQ_DATA;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_exp <= '0;
      end else begin
         r_exp <= (r_exp << 1) | L'(w_rsp_exp);
      end
   end

   assign RSP_VALID = ~RST & w_fifo_valid;
   assign w_pop     = RSP_VALID & RSP_READY;

   bram1be_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESP_DEPTH)
   ) u_fifo (
      .CLK         (CLK),
      .RST         (RST),
      .i_push      (r_exp[L-1]),
      .i_push_data (BRAM_DO),
      .i_pop       (w_pop),
      .o_valid     (w_fifo_valid),
      .o_data      (RSP_DATA),
      .o_count     (w_count)
   );

endmodule

// File: tb/tb_bram1be_client.sv
// Bench for bram1be_client: three instances (PIPELINED 0/1, WRITE_RSP 0/1),
// each with a write-first BRAM model, a reference memory and a response queue.
module tb_bram1be_client;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [NI];
   logic        req_valid [NI];
   logic        req_ready [NI];
   logic [3:0]  req_we    [NI];
   logic [9:0]  req_addr  [NI];
   logic [31:0] req_data  [NI];
   logic        rsp_valid [NI];
   logic        rsp_ready [NI];
   logic [31:0] rsp_data  [NI];
   logic        bram_en   [NI];
   logic [3:0]  bram_we   [NI];
   logic [9:0]  bram_addr [NI];
   logic [31:0] bram_di   [NI];
   logic [31:0] bram_do   [NI];

   logic [31:0] exp_q   [NI][$];
   logic [31:0] hist    [NI][$];
   logic [31:0] ref_mem [NI][16];
   int          first_vld [NI];
   int          n_pop     [NI];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int PIPE = (k == 0) ? 0 : 1;
      logic [31:0] mem [1024];
      logic [31:0] do1;
      logic [31:0] do2;

      bram1be_client #(
         .ADDR_WIDTH (10), .DATA_WIDTH (32), .CHUNKSIZE (8), .WE_WIDTH (4),
         .PIPELINED  (PIPE), .RESP_DEPTH (4), .WRITE_RSP ((k == 2) ? 1 : 0)
      ) u_dut (
         .CLK       (clk),          .RST       (rst[k]),
         .REQ_VALID (req_valid[k]), .REQ_READY (req_ready[k]),
         .REQ_WE    (req_we[k]),    .REQ_ADDR  (req_addr[k]),
         .REQ_DATA  (req_data[k]),  .RSP_VALID (rsp_valid[k]),
         .RSP_READY (rsp_ready[k]), .RSP_DATA  (rsp_data[k]),
         .BRAM_EN   (bram_en[k]),   .BRAM_WE   (bram_we[k]),
         .BRAM_ADDR (bram_addr[k]), .BRAM_DI   (bram_di[k]),
         .BRAM_DO   (bram_do[k])
      );

      // Write-first byte-enable BRAM with optional output register
      always @(posedge clk) begin : bram
         logic [31:0] w;
         w = mem[bram_addr[k]];
         if (bram_en[k]) begin
            for (int b = 0; b < 4; b++)
               if (bram_we[k][b]) w[8*b +: 8] = bram_di[k][8*b +: 8];
            mem[bram_addr[k]] <= w;
            do1 <= w;
         end
         do2 <= do1;
      end
      assign bram_do[k] = (PIPE != 0) ? do2 : do1;

      always @(negedge clk) begin : mon
         logic [31:0] e;
         n_tests++;
         if (exp_q[k].size() > 4) begin
            n_fail++;
            $display("FAIL credit[%0d] outstanding=%0d limit=4", k, exp_q[k].size());
         end
         if (rsp_valid[k] === 1'b1 && first_vld[k] < 0) first_vld[k] = cyc;
         if (rsp_valid[k] === 1'b1 && rsp_ready[k] === 1'b1) begin
            n_tests++;
            n_pop[k]++;
            hist[k].push_back(rsp_data[k]);
            if (exp_q[k].size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected[%0d] got=%h required=none", k, rsp_data[k]);
            end else begin
               e = exp_q[k].pop_front();
               if (rsp_data[k] !== e) begin
                  n_fail++;
                  $display("FAIL rsp_data[%0d] got=%h required=%h", k, rsp_data[k], e);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s got=%h required=%h", nm, got, req);
      end
   endtask

   function automatic logic [31:0] hget(input int k, input int i);
      if (i < hist[k].size()) return hist[k][i];
      return 32'hxxxx_xxxx;
   endfunction

   // Reference: plain memory with byte-lane merge; reads (and writes when
   // WRITE_RSP) expect the post-merge word in request order.
   task automatic model_accept(input int k);
      logic [31:0] m;
      logic [3:0]  a;
      a = req_addr[k][3:0];
      m = ref_mem[k][a];
      for (int b = 0; b < 4; b++)
         if (req_we[k][b]) m[8*b +: 8] = req_data[k][8*b +: 8];
      ref_mem[k][a] = m;
      if (req_we[k] == 4'h0 || k == 2) exp_q[k].push_back(m);
   endtask

   task automatic issue(input int k, input logic [3:0] we, input logic [3:0] a,
                        input logic [31:0] d, output int acc);
      bit done;
      done = 1'b0;
      acc  = -1;
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = {6'd0, a};
      req_data[k]  = d;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (req_ready[k] === 1'b1) begin
            model_accept(k);
            acc  = cyc;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL issue_timeout[%0d] ready=0 required=1", k);
      end
   endtask

   task automatic wait_idle(input int k);
      int t;
      t = 0;
      while (exp_q[k].size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q[k].size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout[%0d] pending=%0d required=0", k, exp_q[k].size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc0, acc1, nacc, p;
      for (int k = 0; k < NI; k++) begin
         rst[k] = 1'b1; req_valid[k] = 1'b1; req_we[k] = 4'hF;
         req_addr[k] = '0; req_data[k] = 32'h5A5A_5A5A; rsp_ready[k] = 1'b1;
         first_vld[k] = -1; n_pop[k] = 0;
      end
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_req_ready[%0d]", k), 32'(req_ready[k]), 0);
            chk($sformatf("reset_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 0);
            chk($sformatf("reset_bram_en[%0d]", k), 32'(bram_en[k]), 0);
            chk($sformatf("reset_bram_we[%0d]", k), 32'(bram_we[k]), 0);
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
         rst[k] = 1'b0; req_valid[k] = 1'b0;
      end

      // Known contents for addresses 0..15 on every instance
      for (int k = 0; k < NI; k++) begin
         for (int a = 0; a < 16; a++) issue(k, 4'hF, 4'(a), $urandom, acc);
         req_valid[k] = 1'b0;
         wait_idle(k);
      end

      // Full write then read: latency 2, no write response
      hist[0].delete(); first_vld[0] = -1;
      issue(0, 4'hF, 4'd5, 32'hDEAD_BEEF, acc);
      issue(0, 4'h0, 4'd5, 32'h0, acc);
      req_valid[0] = 1'b0;
      wait_idle(0);
      chk("p0_read_latency", 32'(first_vld[0] - acc), 2);
      chk("p0_rsp_count", 32'(hist[0].size()), 1);
      chk("p0_read_data", hget(0, 0), 32'hDEAD_BEEF);

      // Byte-enable merge
      hist[0].delete();
      issue(0, 4'hF, 4'd7, 32'hAABB_CCDD, acc);
      issue(0, 4'b0101, 4'd7, 32'h1122_3344, acc);
      issue(0, 4'h0, 4'd7, 32'h0, acc);
      req_valid[0] = 1'b0;
      wait_idle(0);
      chk("be_merge", hget(0, 0), 32'hAA22_CC44);

      // Pipelined back-to-back reads
      first_vld[1] = -1; p = n_pop[1]; acc0 = 0; acc1 = 0;
      for (int a = 0; a < 16; a++) begin
         issue(1, 4'h0, 4'(a), 32'h0, acc);
         if (a == 0) acc0 = acc;
         acc1 = acc;
      end
      req_valid[1] = 1'b0;
      wait_idle(1);
      chk("p1_b2b_span", 32'(acc1 - acc0), 15);
      chk("p1_first_latency", 32'(first_vld[1] - acc0), 3);
      chk("p1_rsp_count", 32'(n_pop[1] - p), 16);

      // Backpressure: credits cap acceptance at RESP_DEPTH
      rsp_ready[0] = 1'b0; nacc = 0; p = n_pop[0];
      for (int i = 0; i < 10; i++) begin
         req_valid[0] = 1'b1; req_we[0] = 4'h0; req_addr[0] = 10'(i);
         @(negedge clk);
         if (req_ready[0] === 1'b1) begin
            model_accept(0);
            nacc++;
         end
         @(posedge clk); #1;
      end
      req_valid[0] = 1'b0;
      chk("bp_accepted", 32'(nacc), 4);
      @(negedge clk);
      chk("bp_ready_full", 32'(req_ready[0]), 0);
      @(posedge clk); #1;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_ready_pop_cycle", 32'(req_ready[0]), 0);
      @(negedge clk);
      chk("bp_ready_after_pop", 32'(req_ready[0]), 1);
      @(posedge clk); #1;
      wait_idle(0);
      chk("bp_drained", 32'(n_pop[0] - p), 4);

      // Reset one cycle after a pipelined read is accepted
      p = n_pop[1];
      issue(1, 4'h0, 4'd3, 32'h0, acc);
      rst[1] = 1'b1; req_we[1] = 4'hF; req_addr[1] = 10'd2; req_data[1] = 32'hBAD0_BAD0;
      exp_q[1].delete();
      repeat (3) begin
         @(negedge clk);
         chk("rst_rsp_valid", 32'(rsp_valid[1]), 0);
         chk("rst_req_ready", 32'(req_ready[1]), 0);
         chk("rst_bram_en", 32'(bram_en[1]), 0);
         chk("rst_bram_we", 32'(bram_we[1]), 0);
         @(posedge clk); #1;
      end
      rst[1] = 1'b0; req_valid[1] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("rst_no_late_rsp", 32'(n_pop[1] - p), 0);
      issue(1, 4'h0, 4'd3, 32'h0, acc);
      issue(1, 4'h0, 4'd2, 32'h0, acc);
      req_valid[1] = 1'b0;
      wait_idle(1);
      chk("rst_after_reads", 32'(n_pop[1] - p), 2);

      // Write responses interleaved with reads
      hist[2].delete();
      issue(2, 4'hF, 4'd9, 32'h1234_5678, acc);
      issue(2, 4'h0, 4'd8, 32'h0, acc);
      issue(2, 4'b0011, 4'd9, 32'h0000_BEEF, acc);
      issue(2, 4'h0, 4'd9, 32'h0, acc);
      req_valid[2] = 1'b0;
      wait_idle(2);
      chk("wrsp_count", 32'(hist[2].size()), 4);
      chk("wrsp_full_write", hget(2, 0), 32'h1234_5678);
      chk("wrsp_merged_write", hget(2, 2), 32'h1234_BEEF);
      chk("wrsp_read_back", hget(2, 3), 32'h1234_BEEF);

      // Randomised traffic with random response backpressure
      for (int k = 0; k < NI; k++) begin
         for (int c = 0; c < 300; c++) begin
            req_valid[k] = ($urandom_range(3) != 0);
            req_we[k]    = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            req_addr[k]  = 10'($urandom_range(15));
            req_data[k]  = $urandom;
            rsp_ready[k] = ($urandom_range(9) < 7);
            @(negedge clk);
            if (req_valid[k] && req_ready[k] === 1'b1) model_accept(k);
            @(posedge clk); #1;
         end
         req_valid[k] = 1'b0;
         rsp_ready[k] = 1'b1;
         wait_idle(k);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
